// File: rtl/stream_enable_mc.sv
`default_nettype none
// ============================================================================
//  Module      : stream_enable_mc
//  Description : Multi-channel stream start enable. Counts outstanding get
//                completions per channel and grants one stream start per
//                cycle to a round-robin selected channel when the downstream
//                sink is ready. stream_ch drives the stream output mux select.
//
//  Ports
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset
//    en          grant enable; completions keep accumulating while low
//    flush       synchronous clear of all pending counters and the rr pointer
//    dst_ready   downstream sink accepts a stream start this cycle
//    get_fin     per-channel single-cycle completion pulses
//    ovf_clr     clears the sticky overflow flags
//    stream_ok   grant issued this cycle (combinational)
//    stream_sel  one-hot granted channel, zero when no grant
//    stream_ch   granted channel index, zero when no grant
//    busy        registered; any pending counter nonzero
//    ovf         sticky per-channel counter overflow flags
//
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_enable_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 3,
    parameter bit BYPASS = 1'b1,
    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              dst_ready,
    input  logic [NUM_CH-1:0] get_fin,
    input  logic              ovf_clr,
    output logic              stream_ok,
    output logic [NUM_CH-1:0] stream_sel,
    output logic [c_CH_W-1:0] stream_ch,
    output logic              busy,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [CNT_W-1:0]  c_PEND_MAX = '1;
    localparam logic [c_CH_W-1:0] c_LAST_CH  = c_CH_W'(NUM_CH - 1);
    localparam logic [c_CH_W:0]   c_NUM_CH   = (c_CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0][CNT_W-1:0] r_pend;
    logic [NUM_CH-1:0][CNT_W-1:0] w_pend_next;
    logic [c_CH_W-1:0]            r_rr_ptr;
    logic [c_CH_W-1:0]            w_rr_next;
    logic [c_CH_W-1:0]            w_win;
    logic                         w_win_vld;
    logic [c_CH_W:0]              w_scan;
    logic [NUM_CH-1:0]            w_req;
    logic [NUM_CH-1:0]            w_grant;
    logic [NUM_CH-1:0]            w_ovf_set;
    logic [NUM_CH-1:0]            r_ovf;
    logic                         r_busy;
    logic                         w_grant_en;

    // A channel requests when it has stored completions, or (in bypass mode)
    // when a completion arrives this very cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_req
            assign w_req[gi] = (r_pend[gi] != '0) | (BYPASS & get_fin[gi]);
        end
    endgenerate

    // Round-robin scan starting at r_rr_ptr. The scan index carries one
    // extra bit so the wrap works for channel counts that are not powers of 2.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_CH_W + 1)'(k);
            if (w_scan >= c_NUM_CH) begin
                w_scan = w_scan - c_NUM_CH;
            end
            if (!w_win_vld && w_req[w_scan[c_CH_W-1:0]]) begin
                w_win     = w_scan[c_CH_W-1:0];
                w_win_vld = 1'b1;
            end
        end
    end

    // rst_n is part of the grant term so bypass completions seen while the
    // block is held in reset never produce a grant.
    assign w_grant_en = en & dst_ready & ~flush & rst_n & w_win_vld;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(gi);
            assign w_grant[gi] = w_grant_en & (w_win == c_IDX);
        end
    endgenerate

    assign stream_ok  = w_grant_en;
    assign stream_sel = w_grant;
    assign stream_ch  = w_grant_en ? w_win : '0;

    // Per-channel pending count update. A completion and a grant on the same
    // channel cancel, which also covers a bypass grant of an empty channel.
    always_comb begin
        w_pend_next = r_pend;
        w_ovf_set   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (flush) begin
                w_pend_next[i] = '0;
            end else if (get_fin[i] && !w_grant[i]) begin
                if (r_pend[i] == c_PEND_MAX) begin
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_pend_next[i] = r_pend[i] + 1'b1;
                end
            end else if (!get_fin[i] && w_grant[i]) begin
                w_pend_next[i] = r_pend[i] - 1'b1;
            end
        end
    end

    always_comb begin
        w_rr_next = r_rr_ptr;
        if (flush) begin
            w_rr_next = '0;
        end else if (w_grant_en) begin
            w_rr_next = (w_win == c_LAST_CH) ? '0 : w_win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_ovf    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_pend   <= w_pend_next;
            r_rr_ptr <= w_rr_next;
            // A new overflow takes priority over a simultaneous clear.
            r_ovf    <= (r_ovf & ~{NUM_CH{ovf_clr}}) | w_ovf_set;
            r_busy   <= |w_pend_next;
        end
    end

    assign busy = r_busy;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stream_enable_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_enable_mc
//  Description : Scoreboard bench for stream_enable_mc. Two instances share
//                the stimulus: one with bypass enabled, one without. A
//                reference model computes each cycle's expected outputs,
//                which a monitor compares against both instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_enable_mc;

    localparam int c_NCH  = 4;
    localparam int c_CHW  = 2;
    localparam int c_CNTW = 3;
    localparam int c_PMAX = (1 << c_CNTW) - 1;

    typedef struct packed {
        logic             ok;
        logic [c_NCH-1:0] sel;
        logic [c_CHW-1:0] ch;
        logic             busy;
        logic [c_NCH-1:0] ovf;
    } out_t;

    typedef struct packed {
        out_t d1;
        out_t d0;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             dst_ready = 1'b0;
    logic [c_NCH-1:0] get_fin = '0;
    logic             ovf_clr = 1'b0;

    logic             ok0, ok1, busy0, busy1;
    logic [c_NCH-1:0] sel0, sel1, ovf0, ovf1;
    logic [c_CHW-1:0] ch0, ch1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_no      = 0;

    rec_t exp_q[$];

    // reference model state, index 0 = bypass instance, 1 = registered
    int               m_pend [2][c_NCH];
    int               m_rr   [2];
    logic [c_NCH-1:0] m_ovf  [2];
    logic             m_busy [2];

    always #5 clk = ~clk;

    stream_enable_mc #(.NUM_CH(c_NCH), .CNT_W(c_CNTW), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .dst_ready(dst_ready),
        .get_fin(get_fin), .ovf_clr(ovf_clr), .stream_ok(ok0), .stream_sel(sel0),
        .stream_ch(ch0), .busy(busy0), .ovf(ovf0)
    );

    stream_enable_mc #(.NUM_CH(c_NCH), .CNT_W(c_CNTW), .BYPASS(1'b0)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .dst_ready(dst_ready),
        .get_fin(get_fin), .ovf_clr(ovf_clr), .stream_ok(ok1), .stream_sel(sel1),
        .stream_ch(ch1), .busy(busy1), .ovf(ovf1)
    );

    // One cycle of behaviour: outputs from the current state and inputs,
    // then advance the state to what it is after the next rising edge.
    task automatic model_step(input int m, input bit byp, output out_t o);
        bit req [c_NCH];
        bit any;
        bit g;
        int win;
        int idx;
        o = '0;
        if (!rst_n) begin
            for (int i = 0; i < c_NCH; i++) m_pend[m][i] = 0;
            m_rr[m]   = 0;
            m_ovf[m]  = '0;
            m_busy[m] = 1'b0;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < c_NCH; i++) begin
            req[i] = (m_pend[m][i] > 0) || (byp && get_fin[i]);
            any    = any | req[i];
        end
        win = -1;
        for (int k = 0; k < c_NCH; k++) begin
            idx = (m_rr[m] + k) % c_NCH;
            if (win < 0 && req[idx]) win = idx;
        end
        g = en && dst_ready && !flush && any;
        o.ok   = g;
        o.sel  = g ? c_NCH'(1 << win) : '0;
        o.ch   = g ? c_CHW'(win) : '0;
        o.busy = m_busy[m];
        o.ovf  = m_ovf[m];
        if (ovf_clr) m_ovf[m] = '0;
        if (flush) begin
            for (int i = 0; i < c_NCH; i++) m_pend[m][i] = 0;
            m_rr[m] = 0;
        end else begin
            for (int i = 0; i < c_NCH; i++) begin
                if (get_fin[i] && !(g && win == i)) begin
                    if (m_pend[m][i] == c_PMAX) m_ovf[m][i] = 1'b1;
                    else m_pend[m][i] = m_pend[m][i] + 1;
                end else if (!get_fin[i] && g && win == i) begin
                    m_pend[m][i] = m_pend[m][i] - 1;
                end
            end
            if (g) m_rr[m] = (win + 1) % c_NCH;
        end
        m_busy[m] = 1'b0;
        for (int i = 0; i < c_NCH; i++) if (m_pend[m][i] > 0) m_busy[m] = 1'b1;
    endtask

    task automatic cyc(input logic [c_NCH-1:0] gf, input logic d, input logic e,
                       input logic f, input logic oc, input logic r);
        out_t o0, o1;
        rec_t rec;
        get_fin   = gf;
        dst_ready = d;
        en        = e;
        flush     = f;
        ovf_clr   = oc;
        rst_n     = r;
        model_step(0, 1'b1, o0);
        model_step(1, 1'b0, o1);
        rec.d0 = o0;
        rec.d1 = o1;
        exp_q.push_back(rec);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_no, act, exp);
        end
    endtask

    // monitor: one expected record per driven cycle, sampled mid-cycle
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            cyc_no++;
            chk("byp_ok",   32'(ok0),   32'(r.d0.ok));
            chk("byp_sel",  32'(sel0),  32'(r.d0.sel));
            chk("byp_ch",   32'(ch0),   32'(r.d0.ch));
            chk("byp_busy", 32'(busy0), 32'(r.d0.busy));
            chk("byp_ovf",  32'(ovf0),  32'(r.d0.ovf));
            chk("reg_ok",   32'(ok1),   32'(r.d1.ok));
            chk("reg_sel",  32'(sel1),  32'(r.d1.sel));
            chk("reg_ch",   32'(ch1),   32'(r.d1.ch));
            chk("reg_busy", 32'(busy1), 32'(r.d1.busy));
            chk("reg_ovf",  32'(ovf1),  32'(r.d1.ovf));
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held with completions and a ready sink: no grants
        repeat (3) cyc(4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // single bypass completion on channel 2
        cyc(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        // accumulate three on channel 1 while the sink stalls, then drain
        for (int n = 0; n < 3; n++) begin
            cyc(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            cyc(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idle(5);
        // round robin over all channels with three pending each
        cyc('0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(14);
        // saturation and sticky overflow clear
        cyc('0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (9) cyc(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        // enable low with pending work, then flush racing a completion
        cyc(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        // single completion: same cycle grant with bypass, next cycle without
        cyc(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        // reset in the middle of pending work
        repeat (2) cyc(4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // randomized traffic
        repeat (600) begin
            logic [c_NCH-1:0] gf;
            logic d, e, f, oc, r;
            gf = c_NCH'($urandom & $urandom);
            d  = ($urandom % 4) != 0;
            e  = ($urandom % 8) != 0;
            f  = ($urandom % 40) == 0;
            oc = !f && (($urandom % 16) == 0);
            r  = ($urandom % 150) != 0;
            cyc(gf, d, e, f, oc, r);
        end
        idle(2);
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_enable_mc.md
Name: stream_enable_mc

Overview:
- Multi-channel, parametrised successor to the single-channel stream enable.
- Each of NUM_CH get engines pulses get_fin when a fetch completes. The block counts outstanding completions per channel instead of keeping a single latch bit.
- Grants one stream start per cycle when the downstream sink is ready, using round-robin arbitration across channels.
- Sits between the get/DMA engines and the stream output mux; stream_ch drives the mux select.

Parameters:
- NUM_CH, 4: number of get/stream channels (2..16).
- CNT_W, 3: width of the per-channel pending counter. It saturates at 2^CNT_W-1.
- BYPASS, 1: 1 = a get_fin may be granted in the same cycle it arrives; 0 = a get_fin must first be registered, so the grant comes one cycle later at the earliest.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  grant enable. While low, no grants are issued but completions still accumulate.
- flush  in  1  synchronous clear of all pending counters.
- dst_ready  in  1  downstream sink can accept a stream start this cycle.
- get_fin  in  NUM_CH  per-channel single-cycle completion pulses; any number may be high at once.
- ovf_clr  in  1  clears the sticky overflow flags.
- stream_ok  out  1  a stream start is granted this cycle (combinational).
- stream_sel  out  NUM_CH  one-hot granted channel; all zero when stream_ok=0.
- stream_ch  out  $clog2(NUM_CH)  index of the granted channel; 0 when stream_ok=0.
- busy  out  1  registered; 1 when any pending counter is nonzero.
- ovf  out  NUM_CH  sticky per-channel overflow flags.

Behaviour:
- Reset (rst_n=0, async):
  - pend[i]=0, rr_ptr=0, ovf=0, busy=0.
  - stream_ok/sel/ch evaluate to 0 because no requests are pending. With BYPASS=1 and get_fin asserted during reset, grants are still suppressed.
  - A reset mid-operation discards all pending counts.
- Request: req[i] = (pend[i]!=0) | (BYPASS & get_fin[i]).
- Grant (combinational, same cycle):
  - A grant is issued when en & dst_ready & |req & ~flush & rst_n.
  - The winner is the first req[i] found scanning upward from rr_ptr, wrapping modulo NUM_CH.
  - stream_ok=1, stream_sel=onehot(winner), stream_ch=winner. At most one grant per cycle.
- Round-robin pointer:
  - On a grant, rr_ptr <= (winner+1) mod NUM_CH.
  - Otherwise rr_ptr holds.
- Counter update, per channel, per cycle:
  - flush=1: pend[i] <= 0 and rr_ptr <= 0. get_fin in the same cycle is dropped; flush wins. ovf is not changed.
  - Otherwise pend[i] <= pend[i] + get_fin[i] - grant[i].
  - Simultaneous get_fin and grant on one channel: count unchanged.
  - BYPASS grant with pend=0: get_fin is consumed and the count stays 0.
- Saturation:
  - If pend[i]==max, get_fin[i]=1 and grant[i]=0, pend[i] holds at max and ovf[i] <= 1.
  - ovf_clr=1 clears all ovf bits. If ovf_clr and a new overflow occur together, the overflow wins (bit stays 1).
- busy <= |pend_next, i.e. busy is the registered OR of the next counter values.
- Latency:
  - BYPASS=1: get_fin to stream_ok is 0 cycles if dst_ready is high and no other channel wins.
  - BYPASS=0: at least 1 cycle.
- Fairness: with all channels continuously requesting and dst_ready=1, each channel is granted exactly once every NUM_CH cycles.
- NUM_CH=1, CNT_W=1, BYPASS=1 reproduces the single-channel latch-until-ready behaviour, except that a completion arriving while one is already pending sets ovf.

Test Plan:
1. Reset/idle: hold rst_n=0 with get_fin=4'b1111 and dst_ready=1 -> stream_ok=0, busy=0, ovf=0. Release reset with inputs idle -> outputs remain 0.
2. Bypass single: BYPASS=1, dst_ready=1, get_fin[2] pulse -> same cycle stream_ok=1, stream_sel=4'b0100, stream_ch=2. Next cycle pend[2]=0, busy=0, rr_ptr=3.
3. Hold then release: dst_ready=0, get_fin[1] pulsed 3 times -> pend[1]=3, busy=1. Raise dst_ready -> 3 consecutive grants on ch1, then busy=0.
4. Round robin: pend=3 on all channels, rr_ptr=0, dst_ready=1 -> grant order 0,1,2,3,0,1,2,3,... for 12 cycles, then stream_ok=0.
5. Saturation: CNT_W=3, dst_ready=0, 9 get_fin[0] pulses -> pend[0]=7, ovf[0]=1. Pulse ovf_clr -> ovf=0 while pend[0] stays 7.
6. Flush/enable/BYPASS=0:
   - en=0 with pending requests -> no grants.
   - flush with a same-cycle get_fin[3] -> all pend=0 and the get_fin is dropped.
   - BYPASS=0, dst_ready=1, get_fin[0] at cycle t -> stream_ok at t+1, not at t.
